fpga_mmio_responder: RTL and testbench

Memory-mapped register block on the far side of the calculator front-end's FPGA bus. It stores operand and opcode writes from the keypad/display front-end, exposes them to the RISC-V core's load/store port while the core computes, captures the core's result, and returns a completion word plus the result to the front-end. It sits between the front-end, the CPU data port and the done/instruction line.

---
 rtl/fpga_mmio_responder_pkg.sv | 31 +++
 rtl/fpga_mmio_responder_if.sv | 31 +++
 rtl/fpga_mmio_responder_addr_decode.sv | 29 ++
 rtl/fpga_mmio_responder.sv | 146 ++++++++++++++
 tb/tb_fpga_mmio_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_mmio_responder_pkg.sv
// Shared definitions for the calculator MMIO responder: FSM states, default
// register addresses, select-vector layout and the completion magic word.
// Optional feature macro used by the responder: MMIO_STATUS_EN.
package fpga_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  localparam logic [31:0] DEF_ADDR_NUM1   = 32'd220;
  localparam logic [31:0] DEF_ADDR_NUM2   = 32'd240;
  localparam logic [31:0] DEF_ADDR_OPSEL  = 32'd260;
  localparam logic [31:0] DEF_ADDR_RESULT = 32'd280;
  localparam logic [31:0] DEF_ADDR_STATUS = 32'd300;
  localparam logic [31:0] DEF_ADDR_IDLE   = 32'd320;

  localparam logic [31:0] DONE_MAGIC = 32'hFFFF_FFFF;

  // One-hot register select layout produced by mmio_addr_decode
  localparam int SEL_W      = 6;
  localparam int SEL_NUM1   = 0;
  localparam int SEL_NUM2   = 1;
  localparam int SEL_OPSEL  = 2;
  localparam int SEL_RESULT = 3;
  localparam int SEL_STATUS = 4;
  localparam int SEL_IDLE   = 5;

endpackage

// File: rtl/fpga_mmio_responder_if.sv
// Bus bundle between the FPGA front-end, the CPU data port and the responder.
// slave: the responder side; master: the front-end/CPU (or bench) side.
// Latency and backpressure are owned by the responder; this is wiring only.
interface fpga_mmio_responder_if;
  logic        fpga_en;
  logic        fpga_write;
  logic [31:0] fpga_addr;
  logic [31:0] fpga_wdata;
  logic [31:0] fpga_rdata;
  logic        fpga_ack;
  logic        cpu_en;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic [31:0] done_word;

  modport slave (
    input  fpga_en, fpga_write, fpga_addr, fpga_wdata,
    input  cpu_en, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output fpga_rdata, fpga_ack, cpu_rdata, cpu_ack, done_word
  );

  modport master (
    output fpga_en, fpga_write, fpga_addr, fpga_wdata,
    output cpu_en, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  fpga_rdata, fpga_ack, cpu_rdata, cpu_ack, done_word
  );
endinterface

// File: rtl/fpga_mmio_responder_addr_decode.sv
// Exact-match byte address to one-hot register select; one copy per port.
// Latency: purely combinational.
// Backpressure: none; unmatched addresses yield an all-zero select.
module mmio_addr_decode
  import fpga_mmio_pkg::*;
#(
  parameter logic [31:0] ADDR_NUM1   = DEF_ADDR_NUM1,
  parameter logic [31:0] ADDR_NUM2   = DEF_ADDR_NUM2,
  parameter logic [31:0] ADDR_OPSEL  = DEF_ADDR_OPSEL,
  parameter logic [31:0] ADDR_RESULT = DEF_ADDR_RESULT,
  parameter logic [31:0] ADDR_STATUS = DEF_ADDR_STATUS,
  parameter logic [31:0] ADDR_IDLE   = DEF_ADDR_IDLE
) (
  input  logic [31:0]      i_addr,
  output logic [SEL_W-1:0] o_sel
);

  // Compare the address against every mapped register
  always_comb begin
    o_sel             = '0;
    o_sel[SEL_NUM1]   = (i_addr == ADDR_NUM1);
    o_sel[SEL_NUM2]   = (i_addr == ADDR_NUM2);
    o_sel[SEL_OPSEL]  = (i_addr == ADDR_OPSEL);
    o_sel[SEL_RESULT] = (i_addr == ADDR_RESULT);
    o_sel[SEL_STATUS] = (i_addr == ADDR_STATUS);
    o_sel[SEL_IDLE]   = (i_addr == ADDR_IDLE);
  end

endmodule

// File: rtl/fpga_mmio_responder.sv
// Calculator MMIO register block: operands in from the front-end, result in from the CPU, done word out.
// Latency: 1 cycle request->ack/rdata on both ports; done_word registered off the state.
// Backpressure: none, every sampled request is acked next cycle (CPU only outside IDLE). Feature: MMIO_STATUS_EN.
module fpga_mmio_responder
  import fpga_mmio_pkg::*;
#(
  parameter logic [31:0] ADDR_NUM1   = DEF_ADDR_NUM1,
  parameter logic [31:0] ADDR_NUM2   = DEF_ADDR_NUM2,
  parameter logic [31:0] ADDR_OPSEL  = DEF_ADDR_OPSEL,
  parameter logic [31:0] ADDR_RESULT = DEF_ADDR_RESULT,
  parameter logic [31:0] ADDR_IDLE   = DEF_ADDR_IDLE,
  parameter logic [31:0] ADDR_STATUS = DEF_ADDR_STATUS
) (
  input  logic                   clk,
  input  logic                   nrst,
  fpga_mmio_responder_if.slave   bus
);

  state_t      r_state;
  logic [31:0] r_num1, r_num2, r_opsel, r_result;
  logic [31:0] r_fpga_rdata, r_cpu_rdata, r_done_word;
  logic        r_fpga_ack, r_cpu_ack;

  logic [SEL_W-1:0] w_fsel, w_csel;
  logic [31:0]      w_fread, w_cread, w_status;
  logic             w_frd, w_fwr, w_cacc, w_crd, w_complete;

  mmio_addr_decode #(
    .ADDR_NUM1(ADDR_NUM1), .ADDR_NUM2(ADDR_NUM2), .ADDR_OPSEL(ADDR_OPSEL),
    .ADDR_RESULT(ADDR_RESULT), .ADDR_STATUS(ADDR_STATUS), .ADDR_IDLE(ADDR_IDLE)
  ) u_fpga_dec (
    .i_addr (bus.fpga_addr),
    .o_sel  (w_fsel)
  );

  mmio_addr_decode #(
    .ADDR_NUM1(ADDR_NUM1), .ADDR_NUM2(ADDR_NUM2), .ADDR_OPSEL(ADDR_OPSEL),
    .ADDR_RESULT(ADDR_RESULT), .ADDR_STATUS(ADDR_STATUS), .ADDR_IDLE(ADDR_IDLE)
  ) u_cpu_dec (
    .i_addr (bus.cpu_addr),
    .o_sel  (w_csel)
  );

  // Both ports share the same read view; the sink address always reads zero
  function automatic logic [31:0] f_rd_mux(input logic [SEL_W-1:0] sel);
    logic [31:0] v;
    v = '0;
    if (!sel[SEL_IDLE]) begin
      v = ({32{sel[SEL_NUM1]}}   & r_num1)   |
          ({32{sel[SEL_NUM2]}}   & r_num2)   |
          ({32{sel[SEL_OPSEL]}}  & r_opsel)  |
          ({32{sel[SEL_RESULT]}} & r_result) |
          ({32{sel[SEL_STATUS]}} & w_status);
    end
    return v;
  endfunction

  assign w_fread = f_rd_mux(w_fsel);
  assign w_cread = f_rd_mux(w_csel);

  assign w_frd = bus.fpga_en & ~bus.fpga_write;
  assign w_fwr = bus.fpga_en &  bus.fpga_write;
  // CPU port is dead while the front-end owns the registers
  assign w_cacc = (r_state != ST_IDLE) & (bus.cpu_read | bus.cpu_write);
  assign w_crd  = bus.cpu_read & ~bus.cpu_write;
  assign w_complete = (r_state == ST_COMPUTE) & bus.cpu_en & bus.cpu_write & w_csel[SEL_RESULT];

`ifdef MMIO_STATUS_EN
  logic [7:0] r_op_count;

  assign w_status = {16'b0, r_op_count, 6'b0, r_state};

  // Count completed runs; wraps naturally at 8 bits
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_op_count <= '0;
    end else if (w_complete) begin
      r_op_count <= r_op_count + 8'd1;
    end
  end
`else
  assign w_status = '0;
`endif

  // Control FSM plus all registered register-file state and port outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_num1       <= '0;
      r_num2       <= '0;
      r_opsel      <= '0;
      r_result     <= '0;
      r_fpga_rdata <= '0;
      r_fpga_ack   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_ack    <= 1'b0;
      r_done_word  <= '0;
    end else begin
      r_fpga_ack <= bus.fpga_en;
      if (w_frd) r_fpga_rdata <= w_fread;
      r_cpu_ack <= w_cacc;
      if (w_cacc && w_crd) r_cpu_rdata <= w_cread;

      case (r_state)
        ST_IDLE: begin
          if (w_fwr) begin
            if (w_fsel[SEL_NUM1])  r_num1  <= bus.fpga_wdata;
            if (w_fsel[SEL_NUM2])  r_num2  <= bus.fpga_wdata;
            if (w_fsel[SEL_OPSEL]) r_opsel <= bus.fpga_wdata;
          end
          if (bus.cpu_en) r_state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          // An aborted run wins over a same-cycle result store
          if (!bus.cpu_en) begin
            r_state <= ST_IDLE;
          end else if (w_complete) begin
            r_result    <= bus.cpu_wdata;
            r_state     <= ST_DONE;
            r_done_word <= DONE_MAGIC;
          end
        end
        ST_DONE: begin
          if (w_frd && w_fsel[SEL_RESULT]) begin
            r_state     <= ST_READOUT;
            r_done_word <= '0;
          end
        end
        ST_READOUT: begin
          if (w_fwr && w_fsel[SEL_NUM1]) begin
            r_num1  <= bus.fpga_wdata;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fpga_rdata = r_fpga_rdata;
  assign bus.fpga_ack   = r_fpga_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.done_word  = r_done_word;

endmodule

// File: tb/tb_fpga_mmio_responder.sv
// Self-checking bench for fpga_mmio_responder: directed front-end/CPU sequences,
// a transaction-level model compared against the DUT every negedge, and literal
// spot checks at key points. Status checks only apply with MMIO_STATUS_EN.
module tb_fpga_mmio_responder;

  localparam logic [31:0] A_NUM1 = 32'd220;
  localparam logic [31:0] A_NUM2 = 32'd240;
  localparam logic [31:0] A_OPS  = 32'd260;
  localparam logic [31:0] A_RES  = 32'd280;
  localparam logic [31:0] A_STAT = 32'd300;
  localparam logic [31:0] A_SINK = 32'd320;

  localparam int M_IDLE = 0, M_COMP = 1, M_DONE = 2, M_READ = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  fpga_mmio_responder_if bus();

  fpga_mmio_responder dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;
  logic [31:0] m_num1, m_num2, m_ops, m_res;
  logic [7:0]  m_cnt;
  logic [31:0] m_frd, m_crd;
  logic        m_fack, m_cack;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == A_NUM1) return m_num1;
    if (a == A_NUM2) return m_num2;
    if (a == A_OPS)  return m_ops;
    if (a == A_RES)  return m_res;
`ifdef MMIO_STATUS_EN
    if (a == A_STAT) return {16'b0, m_cnt, 6'b0, m_mode[1:0]};
`endif
    return 32'h0;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_mode <= M_IDLE;
      m_num1 <= 0; m_num2 <= 0; m_ops <= 0; m_res <= 0; m_cnt <= 0;
      m_frd <= 0; m_crd <= 0; m_fack <= 0; m_cack <= 0;
    end else begin
      m_fack <= bus.fpga_en;
      if (bus.fpga_en && !bus.fpga_write) m_frd <= m_read(bus.fpga_addr);
      m_cack <= (m_mode != M_IDLE) && (bus.cpu_read || bus.cpu_write);
      if (m_mode != M_IDLE && bus.cpu_read && !bus.cpu_write) m_crd <= m_read(bus.cpu_addr);
      if (m_mode == M_IDLE) begin
        if (bus.fpga_en && bus.fpga_write) begin
          if (bus.fpga_addr == A_NUM1) m_num1 <= bus.fpga_wdata;
          if (bus.fpga_addr == A_NUM2) m_num2 <= bus.fpga_wdata;
          if (bus.fpga_addr == A_OPS)  m_ops  <= bus.fpga_wdata;
        end
        if (bus.cpu_en) m_mode <= M_COMP;
      end else if (m_mode == M_COMP) begin
        if (!bus.cpu_en) m_mode <= M_IDLE;
        else if (bus.cpu_write && bus.cpu_addr == A_RES) begin
          m_res <= bus.cpu_wdata; m_cnt <= m_cnt + 8'd1; m_mode <= M_DONE;
        end
      end else if (m_mode == M_DONE) begin
        if (bus.fpga_en && !bus.fpga_write && bus.fpga_addr == A_RES) m_mode <= M_READ;
      end else begin
        if (bus.fpga_en && bus.fpga_write && bus.fpga_addr == A_NUM1) begin
          m_num1 <= bus.fpga_wdata; m_mode <= M_IDLE;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp_fpga_ack",   {31'b0, bus.fpga_ack}, {31'b0, m_fack});
      check("cmp_fpga_rdata", bus.fpga_rdata, m_frd);
      check("cmp_cpu_ack",    {31'b0, bus.cpu_ack}, {31'b0, m_cack});
      check("cmp_cpu_rdata",  bus.cpu_rdata, m_crd);
      check("cmp_done_word",  bus.done_word, (m_mode == M_DONE) ? 32'hFFFF_FFFF : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fpga_wr(input logic [31:0] a, input logic [31:0] d);
    bus.fpga_en = 1'b1; bus.fpga_write = 1'b1; bus.fpga_addr = a; bus.fpga_wdata = d;
    cyc();
    bus.fpga_en = 1'b0; bus.fpga_write = 1'b0;
  endtask

  task automatic fpga_rd(input logic [31:0] a, output logic [31:0] d);
    bus.fpga_en = 1'b1; bus.fpga_write = 1'b0; bus.fpga_addr = a;
    cyc();
    d = bus.fpga_rdata;
    bus.fpga_en = 1'b0;
  endtask

  logic [31:0] rd;
  int acks;

  initial begin
    bus.fpga_en = 0; bus.fpga_write = 0; bus.fpga_addr = 0; bus.fpga_wdata = 0;
    bus.cpu_en = 0; bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    repeat (3) cyc();
    check("rst_fpga_rdata", bus.fpga_rdata, 32'h0);
    check("rst_fpga_ack",   {31'b0, bus.fpga_ack}, 32'h0);
    check("rst_cpu_rdata",  bus.cpu_rdata, 32'h0);
    check("rst_cpu_ack",    {31'b0, bus.cpu_ack}, 32'h0);
    check("rst_done_word",  bus.done_word, 32'h0);
    chk_on = 1'b1;
    nrst = 1'b1;
    cyc();

    // Operand load and readback
    fpga_wr(A_NUM1, 32'h12);
    check("wr_ack_first", {31'b0, bus.fpga_ack}, 32'h1);
    cyc();
    check("ack_single", {31'b0, bus.fpga_ack}, 32'h0);
    fpga_wr(A_NUM2, 32'h34);
    fpga_wr(A_OPS, 32'h2);
    fpga_rd(A_NUM1, rd); check("rd_num1", rd, 32'h12);
    fpga_rd(A_NUM2, rd); check("rd_num2", rd, 32'h34);
    fpga_rd(A_OPS, rd);  check("rd_opsel", rd, 32'h2);

    // Compute: CPU read and a dropped FPGA write in the same cycle
    bus.cpu_en = 1'b1; cyc();
    bus.cpu_read = 1'b1; bus.cpu_addr = A_NUM1;
    bus.fpga_en = 1'b1; bus.fpga_write = 1'b1; bus.fpga_addr = A_NUM1; bus.fpga_wdata = 32'h99;
    cyc();
    check("cpu_rd_num1", bus.cpu_rdata, 32'h12);
    check("cpu_rd_ack",  {31'b0, bus.cpu_ack}, 32'h1);
    check("fpga_drop_ack", {31'b0, bus.fpga_ack}, 32'h1);
    bus.cpu_read = 1'b0; bus.fpga_en = 1'b0; bus.fpga_write = 1'b0;
    fpga_rd(A_NUM1, rd); check("num1_kept", rd, 32'h12);

    // Completion and readout
    bus.cpu_write = 1'b1; bus.cpu_addr = A_RES; bus.cpu_wdata = 32'h46;
    cyc();
    check("done_set", bus.done_word, 32'hFFFF_FFFF);
    bus.cpu_write = 1'b0; bus.cpu_en = 1'b0;
    cyc();
    check("done_hold", bus.done_word, 32'hFFFF_FFFF);
    fpga_rd(A_RES, rd);
    check("rd_result", rd, 32'h46);
    check("done_clear", bus.done_word, 32'h0);
    fpga_wr(A_NUM1, 32'h5);
    fpga_rd(A_NUM1, rd); check("readout_num1", rd, 32'h5);

    // Aborted run
    bus.cpu_en = 1'b1; cyc();
    bus.cpu_en = 1'b0; cyc();
    check("abort_done", bus.done_word, 32'h0);
    fpga_wr(A_NUM2, 32'h77);
    fpga_rd(A_NUM2, rd); check("abort_idle_wr", rd, 32'h77);
    fpga_rd(A_RES, rd);  check("abort_result", rd, 32'h46);
    bus.cpu_read = 1'b1; bus.cpu_addr = A_NUM1; cyc();
    check("idle_cpu_noack", {31'b0, bus.cpu_ack}, 32'h0);
    bus.cpu_read = 1'b0;
    fpga_rd(A_STAT, rd);
`ifdef MMIO_STATUS_EN
    check("status_one", rd, 32'h0000_0100);
`else
    check("status_unmapped", rd, 32'h0);
`endif

    // Held write to the sink address, then an unmapped read
    acks = 0;
    bus.fpga_en = 1'b1; bus.fpga_write = 1'b1; bus.fpga_addr = A_SINK; bus.fpga_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (bus.fpga_ack) acks++;
    end
    bus.fpga_en = 1'b0; bus.fpga_write = 1'b0;
    check("sink_acks", acks, 32'd50);
    fpga_rd(32'h400, rd); check("rd_unmapped", rd, 32'h0);
    fpga_rd(A_NUM1, rd);  check("sink_num1", rd, 32'h5);
    fpga_rd(A_NUM2, rd);  check("sink_num2", rd, 32'h77);
    fpga_rd(A_OPS, rd);   check("sink_opsel", rd, 32'h2);

`ifdef MMIO_STATUS_EN
    // 255 more runs make 256 completions total: count wraps to zero
    for (int r = 0; r < 255; r++) begin
      bus.cpu_en = 1'b1; cyc();
      bus.cpu_write = 1'b1; bus.cpu_addr = A_RES; bus.cpu_wdata = r; cyc();
      bus.cpu_write = 1'b0; bus.cpu_en = 1'b0;
      fpga_rd(A_RES, rd);
      fpga_wr(A_NUM1, 32'h5);
    end
    fpga_rd(A_STAT, rd); check("status_wrap", rd, 32'h0);
`endif

    // Reset in the middle of a compute window
    bus.cpu_en = 1'b1; cyc();
    bus.cpu_read = 1'b1; bus.cpu_addr = A_NUM2; cyc();
    bus.cpu_read = 1'b0;
    check("pre_rst_cpu_rdata", bus.cpu_rdata, 32'h77);
    #1 nrst = 1'b0;
    #1;
    check("mid_rst_fpga_rdata", bus.fpga_rdata, 32'h0);
    check("mid_rst_cpu_rdata",  bus.cpu_rdata, 32'h0);
    check("mid_rst_cpu_ack",    {31'b0, bus.cpu_ack}, 32'h0);
    check("mid_rst_done",       bus.done_word, 32'h0);
    bus.cpu_en = 1'b0;
    cyc(); cyc();
    nrst = 1'b1;
    cyc();
    fpga_rd(A_NUM2, rd); check("post_rst_num2", rd, 32'h0);
    bus.cpu_read = 1'b1; bus.cpu_addr = A_NUM1; cyc();
    check("post_rst_idle", {31'b0, bus.cpu_ack}, 32'h0);
    bus.cpu_read = 1'b0;
    cyc();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
